// File: rtl/sync_fifo_ext_if.sv
// Bus bundle between a FIFO user (master) and sync_fifo_ext (slave).
interface sync_fifo_ext_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              clr;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, din, wr_en, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clr, din, wr_en, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, registered or first-word-fall-through
// read, almost-full/almost-empty thresholds and sticky overflow/underflow.
module sync_fifo_ext #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic           clk,
    input logic           rst_n,
    sync_fifo_ext_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty_w;
    logic              full_w;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] dout_w;

    // Status comes only from the registered level; clr suppresses both ports.
    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LVL_FULL);
    assign wr_acc  = bus.wr_en && !full_w && !bus.clr;
    assign rd_acc  = bus.rd_en && !empty_w && !bus.clr;

    // In FWFT mode the head word is shown directly; once empty, the last
    // shown word is held in dout_q so dout never glitches to stale memory.
    assign dout_w = ((FWFT != 0) && !empty_w) ? mem_q[rd_ptr_q] : dout_q;

    // Next-state for pointers, level, read data and sticky error flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (bus.wr_en && full_w) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
            if (FWFT == 0) begin
                dout_valid_d = rd_acc;
            end
        end

        if (FWFT != 0) begin
            dout_d = dout_w;
        end else if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array; deliberately has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout         = dout_w;
    assign bus.dout_valid   = (FWFT != 0) ? !empty_w : dout_valid_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (level_q >= LVL_AF);
    assign bus.almost_empty = (level_q <= LVL_AE);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 Parameter: DATA_W, 64, data width in bits (>=1).
REQ-002 Parameter: DEPTH, 16, storage words; any integer >=2, power of two not required.
REQ-003 Parameter: FWFT, 0, read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter: AF_LEVEL, DEPTH-2, almost_full threshold (1..DEPTH).
REQ-005 Parameter: AE_LEVEL, 2, almost_empty threshold (0..DEPTH-1).
REQ-006 Port: clk  in  1  clock, all state on rising edge.
REQ-007 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Port: clr  in  1  synchronous flush, active-high.
REQ-009 Port: din  in  DATA_W  write data.
REQ-010 Port: wr_en  in  1  write request.
REQ-011 Port: rd_en  in  1  read request (FWFT=1: pop of presented word).
REQ-012 Port: dout  out  DATA_W  read data.
REQ-013 Port: dout_valid  out  1  dout carries a valid word.
REQ-014 Port: full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-015 Port: level  out  $clog2(DEPTH+1)  stored word count.
REQ-016 Port: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Write accepted iff wr_en && !full; a same-cycle read never frees space for that write.
REQ-018 Read accepted iff rd_en && !empty.
REQ-019 Pointers wrap from DEPTH-1 to 0 for every DEPTH.
REQ-020 level: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither occur; range 0..DEPTH.
REQ-021 empty = (level==0); full = (level==DEPTH); almost_full = (level>=AF_LEVEL); almost_empty = (level<=AE_LEVEL); all derived from registered level, no combinational path from inputs.
REQ-022 FWFT=0: dout loads the head word on the edge after an accepted read; dout_valid high for exactly that one cycle; dout holds its last value otherwise; read of empty FIFO does not change dout.
REQ-023 FWFT=1: dout_valid = !empty; dout shows the head word whenever dout_valid=1; accepted read presents the next word (or deasserts dout_valid) in the following cycle.
REQ-024 FWFT=1: write into an empty FIFO gives dout_valid=1 and dout=din one cycle after the write edge.
REQ-025 overflow sets when wr_en && full; underflow sets when rd_en && empty; both remain set until clr or reset.
REQ-026 clr: pointers and level to 0, dout_valid to 0, overflow/underflow to 0 at next edge; clr takes priority over same-cycle wr_en/rd_en, which are dropped and not flagged; dout value retained.
REQ-027 Memory contents are not reset and not cleared by clr.

Reset
REQ-028 While rst_n=0: level=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0, pointers=0.
REQ-029 Reset asserted mid-operation discards all stored words; first accepted write after release lands at address 0.

Verification
REQ-030 FWFT=0, DEPTH=16: write 0x1..0x10 -> full=1, level=16, almost_full from level 14; 17th write -> overflow=1, level stays 16; 16 reads -> dout 0x1..0x10 each one cycle after rd_en, dout_valid pulses.
REQ-031 DEPTH=5: 12 write/read cycles at level 3 with simultaneous wr_en/rd_en -> level constant 3, data order preserved across pointer wrap at 4->0.
REQ-032 FWFT=1: write 0xAA into empty FIFO -> next cycle dout=0xAA, dout_valid=1 without rd_en; rd_en -> following cycle dout_valid=0, empty=1.
REQ-033 Empty FIFO, rd_en=1 -> underflow=1, level=0, dout unchanged; then clr=1 with wr_en=1 -> level=0, underflow=0, no overflow.
REQ-034 Full FIFO with wr_en=1 and rd_en=1 same cycle -> read accepted, write dropped, overflow=1, level=DEPTH-1.
REQ-035 Load 7 words, assert rst_n=0 mid-stream -> all outputs at REQ-028 values immediately; after release, write 0x55 and read returns 0x55.
